pal_cfg_loader: RTL and testbench
=================================

# pal_cfg_loader

Upstream configuration stage for the PAL. Accepts the configuration bitstream as parallel words over a valid/ready handshake and serialises it onto the PAL's `CFG` input, generating the PAL's `CLK` pulse for every bit. The PAL's own shift chain is unchanged. On completion, the PAL holds the full `2*N*P + P*M`-bit configuration and the loader reports `DONE`.

## Interface
- `N`, default 4: PAL input variables (matches PAL `N`)
- `M`, default 1: PAL outputs (matches PAL `M`)
- `P`, default 3: PAL intermediate product terms (matches PAL `P`)
- `W`, default 8: input word width, ≥1
- `CLK`  in  1: system clock, all logic on rising edge
- `RST_N`  in  1: reset, synchronous, active-low
- `START`  in  1: begin a load; sampled only in IDLE
- `DIN`  in  W: bitstream word; bit j of word k = stream bit k*W+j
- `DIN_VALID`  in  1: `DIN` valid
- `DIN_READY`  out  1: loader accepts `DIN` this cycle
- `BUSY`  out  1: load in progress
- `DONE`  out  1: one-cycle pulse, load complete
- `PAL_CLK`  out  1: drives PAL `CLK`
- `PAL_CFG`  out  1: drives PAL `CFG`

## Operation
- `LEN = 2*N*P + P*M` and `WORDS = ceil(LEN/W)`. Stream bit 0 is shifted first.
- FSM states and transitions:
  - IDLE → FETCH on `START`.
  - FETCH → SETUP on `DIN_VALID && DIN_READY`, which latches the word into the shift register.
  - SETUP → PULSE, always.
  - PULSE → SETUP if more bits remain in the current word and the total shifted is below `LEN`.
  - PULSE → FETCH if the word is exhausted and the total is below `LEN`.
  - PULSE → DONE_ST if the total reaches `LEN`.
  - DONE_ST → IDLE, always.
- Per-state outputs:
  - SETUP: `PAL_CFG` = current bit; `PAL_CLK` = 0.
  - PULSE: `PAL_CFG` held; `PAL_CLK` = 1.
  - All other states: `PAL_CLK` = 0.
- Handshake outputs:
  - `DIN_READY` = 1 only in FETCH.
  - `BUSY` = 1 in FETCH, SETUP and PULSE.
  - `DONE` = 1 only in DONE_ST.
- Unused high bits of the final word (`WORDS*W − LEN`) are discarded and never pulsed.
- `START` outside IDLE is ignored, including in DONE_ST.
- A `DIN_VALID` that is low in FETCH stalls the load indefinitely, with `PAL_CLK` held low.
- Bit counter width is `$clog2(LEN+1)`; in-word index width is `$clog2(W)`, minimum 1. Counters saturate at their terminal value, and the terminal value is checked before any wrap.

## Timing
- All outputs are registered. Reset values: `PAL_CLK`=0, `PAL_CFG`=0, `DIN_READY`=0, `BUSY`=0, `DONE`=0, state IDLE, counters 0.
- `START` sampled at edge e0 → `BUSY`=1 and `DIN_READY`=1 from e0.
- Each bit costs 2 cycles. `PAL_CFG` is stable for one full cycle before each `PAL_CLK` rising edge and stays stable until `PAL_CLK` falls.
- Each word costs 1 FETCH cycle (minimum) plus 2 cycles per used bit.
- With `DIN_VALID` held high, `DONE` rises at e0 + `WORDS` + 2*`LEN` and lasts exactly 1 cycle.
- `RST_N` low at any edge mid-load → IDLE at that edge, with `PAL_CLK` and `PAL_CFG` low on the next cycle. The partially loaded PAL is invalid and a full reload is required. No pending word is retained.
- Exactly `LEN` `PAL_CLK` rising edges occur per completed load.

## Structure
- Shared package `pal_pkg` holds:
  - the state enum (IDLE, FETCH, SETUP, PULSE, DONE_ST);
  - the function `pal_bitstream_len(N,M,P)`, reused by the PAL testbenches.
- Single module with no sub-module. The word shift register is inline.

## Test plan
- **Default load.** N=4, M=1, P=3, W=8, `DIN_VALID` always high, words 0x04, 0x41, 0x10, 0x04.
  - Required: 27 `PAL_CLK` pulses; `PAL_CFG` sampled on those pulses equals 27'b100000100000100000100000100 (LSB first).
  - Required: `DONE` at e0+58; PAL `OUTPUT_VALS` then matches that configuration for `INPUT_VARS`=4'b1111 and 4'b0000.
- **Backpressure.** Same load, `DIN_VALID` low for 5 cycles before word 2.
  - Required: no `PAL_CLK` edges during the stall; 27 pulses total; `DONE` at e0+63.
- **Exact fit.** N=2, M=2, P=2, W=4 (LEN=12, WORDS=3), words 0xA, 0x5, 0xF.
  - Required: 12 pulses; stream 12'hF5A (LSB first); `DONE` at e0+27.
- **Reset mid-load.** `RST_N` low for 1 cycle at e20.
  - Required: all outputs 0 at the next cycle; new `START` → fresh 27-bit load completes with `DONE` at restart+58.
- **Ignored start.** `START` pulsed at e5, e30 and during DONE_ST.
  - Required: exactly one load, one `DONE` pulse, and `BUSY` returns to 0 after DONE_ST.

Source files
------------

// File: rtl/pal_pkg.sv
// pal_pkg: shared state encoding and bitstream length helper for the PAL and its loader
package pal_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, SETUP, PULSE, DONE_ST} state_t;
  function automatic int pal_bitstream_len(input int n, input int m, input int p);
    return 2 * n * p + p * m;
  endfunction
endpackage

// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: serialises handshaked configuration words onto the PAL CFG/CLK shift chain
module pal_cfg_loader
  import pal_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 1,
  parameter int P = 3,
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic [W-1:0] DIN,
  input  logic         DIN_VALID,
  output logic         DIN_READY,
  output logic         BUSY,
  output logic         DONE,
  output logic         PAL_CLK,
  output logic         PAL_CFG
);
  localparam int LEN = pal_bitstream_len(N, M, P);
  localparam int BW = $clog2(LEN + 1);
  localparam int IW = W > 1 ? $clog2(W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(LEN - 1);
  localparam logic [BW-1:0] CNT_MAX = BW'(LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);
  state_t state, next;
  logic [W-1:0] sreg, shifted;
  logic [BW-1:0] cnt;
  logic [IW-1:0] idx;
  logic accept;
  assign accept = state == FETCH && DIN_VALID && DIN_READY;
  assign shifted = sreg >> 1;
  // cnt is the stream index of the bit being pulsed, so the last bit ends the load
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = START ? FETCH : IDLE;
      FETCH:   next = accept ? SETUP : FETCH;
      SETUP:   next = PULSE;
      PULSE:   next = cnt == LAST_BIT ? DONE_ST : idx == LAST_IDX ? FETCH : SETUP;
      DONE_ST: next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else state <= next;
  end
  // Outputs are registered from the next state so they line up with the state register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      DIN_READY <= 1'b0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      PAL_CLK <= 1'b0;
      PAL_CFG <= 1'b0;
      sreg <= '0;
      cnt <= '0;
      idx <= '0;
    end else begin
      DIN_READY <= next == FETCH;
      BUSY <= next inside {FETCH, SETUP, PULSE};
      DONE <= next == DONE_ST;
      PAL_CLK <= next == PULSE;
      if (state == IDLE && START) begin
        cnt <= '0;
        idx <= '0;
      end
      if (accept) begin
        sreg <= DIN;
        idx <= '0;
        PAL_CFG <= DIN[0];
      end
      if (state == PULSE) begin
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        if (idx != LAST_IDX) idx <= idx + 1'b1;
        if (next == SETUP) begin
          sreg <= shifted;
          PAL_CFG <= shifted[0];
        end
      end
    end
  end
endmodule

// File: tb/tb_pal_cfg_loader.sv
// tb_pal_cfg_loader: directed tests of the loader in the default and exact-fit configurations
module tb_pal_cfg_loader;
  logic clk = 0, rst_n = 0, start = 0, din_valid = 0;
  logic [7:0] din = '0;
  logic din_ready, busy, done, pal_clk, pal_cfg;
  logic start2 = 0, din_valid2 = 0;
  logic [3:0] din2 = '0;
  logic din_ready2, busy2, done2, pal_clk2, pal_cfg2;
  int n_checks = 0, n_fail = 0, cyc = 0;
  logic [7:0] w[4] = '{8'h04, 8'h41, 8'h10, 8'h04};
  logic [3:0] w2[3] = '{4'hA, 4'h5, 4'hF};
  pal_cfg_loader dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .DIN(din), .DIN_VALID(din_valid),
    .DIN_READY(din_ready), .BUSY(busy), .DONE(done), .PAL_CLK(pal_clk), .PAL_CFG(pal_cfg)
  );
  pal_cfg_loader #(.N(2), .M(2), .P(2), .W(4)) dut2 (
    .CLK(clk), .RST_N(rst_n), .START(start2), .DIN(din2), .DIN_VALID(din_valid2),
    .DIN_READY(din_ready2), .BUSY(busy2), .DONE(done2), .PAL_CLK(pal_clk2), .PAL_CFG(pal_cfg2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // Record CFG at every PAL_CLK rising edge and confirm it was already set the cycle before
  logic hist[0:1023];
  logic hist2[0:1023];
  int pulses = 0, cfg_err = 0, pulses2 = 0, cfg_err2 = 0;
  logic clk_q = 0, cfg_q = 0, clk_q2 = 0, cfg_q2 = 0;
  always @(negedge clk) begin
    if (pal_clk && !clk_q) begin
      if (pulses < 1024) hist[pulses] = pal_cfg;
      pulses++;
      if (pal_cfg !== cfg_q) cfg_err++;
    end
    clk_q = pal_clk;
    cfg_q = pal_cfg;
    if (pal_clk2 && !clk_q2) begin
      if (pulses2 < 1024) hist2[pulses2] = pal_cfg2;
      pulses2++;
      if (pal_cfg2 !== cfg_q2) cfg_err2++;
    end
    clk_q2 = pal_clk2;
    cfg_q2 = pal_cfg2;
  end
  function automatic logic [31:0] get_stream(input bit second, input int base, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r[i] = second ? hist2[base + i] : hist[base + i];
    return r;
  endfunction
  task automatic drive_load(input int stall, input int sa, input int sb, input bit sdone,
                            output int done_at, output int done_cnt, output int clk_in_stall,
                            output int base, output int err_base);
    int e0, t, wi, stalled;
    base = pulses;
    err_base = cfg_err;
    done_at = -1;
    done_cnt = 0;
    clk_in_stall = 0;
    wi = 0;
    stalled = 0;
    start = 1;
    din_valid = 1;
    din = w[0];
    @(negedge clk);
    start = 0;
    e0 = cyc;
    for (int k = 0; k < 400; k++) begin
      t = cyc - e0;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = t;
      end
      if (done_at >= 0 && t >= done_at + 4) break;
      start = (t + 1 == sa) || (t + 1 == sb) || (sdone && done);
      if (din_ready && wi < 4) begin
        if (wi == 2 && stalled < stall) begin
          din_valid = 0;
          stalled++;
          if (pal_clk) clk_in_stall++;
        end else begin
          din_valid = 1;
          din = w[wi];
          wi++;
        end
      end
      @(negedge clk);
    end
    start = 0;
    din_valid = 0;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({din_ready, busy, done, pal_clk, pal_cfg} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000", {din_ready, busy, done, pal_clk, pal_cfg});
    end
    n_checks++;
    if ({din_ready2, busy2, done2, pal_clk2, pal_cfg2} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs_fit: got %b expected 00000", {din_ready2, busy2, done2, pal_clk2, pal_cfg2});
    end
    rst_n = 1;
    @(negedge clk);
  endtask
  task automatic test_default();
    int done_at, done_cnt, cis, base, eb;
    drive_load(0, -1, -1, 0, done_at, done_cnt, cis, base, eb);
    n_checks++;
    if (done_at !== 58) begin n_fail++; $display("FAIL default_done_at: got %0d expected 58", done_at); end
    n_checks++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL default_done_width: got %0d expected 1", done_cnt); end
    n_checks++;
    if (pulses - base !== 27) begin n_fail++; $display("FAIL default_pulses: got %0d expected 27", pulses - base); end
    n_checks++;
    if (get_stream(0, base, 27) !== 32'h0410_4104) begin
      n_fail++;
      $display("FAIL default_stream: got %h expected 04104104", get_stream(0, base, 27));
    end
    n_checks++;
    if (cfg_err - eb !== 0) begin n_fail++; $display("FAIL default_cfg_setup: got %0d unstable bits expected 0", cfg_err - eb); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL default_busy_after: got %b expected 0", busy); end
  endtask
  task automatic test_backpressure();
    int done_at, done_cnt, cis, base, eb;
    drive_load(5, -1, -1, 0, done_at, done_cnt, cis, base, eb);
    n_checks++;
    if (done_at !== 63) begin n_fail++; $display("FAIL bp_done_at: got %0d expected 63", done_at); end
    n_checks++;
    if (cis !== 0) begin n_fail++; $display("FAIL bp_clk_in_stall: got %0d expected 0", cis); end
    n_checks++;
    if (pulses - base !== 27) begin n_fail++; $display("FAIL bp_pulses: got %0d expected 27", pulses - base); end
    n_checks++;
    if (get_stream(0, base, 27) !== 32'h0410_4104) begin
      n_fail++;
      $display("FAIL bp_stream: got %h expected 04104104", get_stream(0, base, 27));
    end
  endtask
  task automatic test_exact_fit();
    int e0, t, wi, done_at, done_cnt, base, eb;
    base = pulses2;
    eb = cfg_err2;
    done_at = -1;
    done_cnt = 0;
    wi = 0;
    start2 = 1;
    din_valid2 = 1;
    din2 = w2[0];
    @(negedge clk);
    start2 = 0;
    e0 = cyc;
    for (int k = 0; k < 200; k++) begin
      t = cyc - e0;
      if (done2) begin
        done_cnt++;
        if (done_at < 0) done_at = t;
      end
      if (done_at >= 0 && t >= done_at + 3) break;
      if (din_ready2 && wi < 3) begin
        din2 = w2[wi];
        wi++;
      end
      @(negedge clk);
    end
    din_valid2 = 0;
    n_checks++;
    if (done_at !== 27) begin n_fail++; $display("FAIL fit_done_at: got %0d expected 27", done_at); end
    n_checks++;
    if (pulses2 - base !== 12) begin n_fail++; $display("FAIL fit_pulses: got %0d expected 12", pulses2 - base); end
    n_checks++;
    if (get_stream(1, base, 12) !== 32'h0000_0F5A) begin
      n_fail++;
      $display("FAIL fit_stream: got %h expected 00000f5a", get_stream(1, base, 12));
    end
    n_checks++;
    if (cfg_err2 - eb !== 0) begin n_fail++; $display("FAIL fit_cfg_setup: got %0d unstable bits expected 0", cfg_err2 - eb); end
  endtask
  task automatic test_reset_mid_load();
    int done_at, done_cnt, cis, base, eb;
    start = 1;
    din_valid = 1;
    din = 8'h04;
    @(negedge clk);
    start = 0;
    repeat (19) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    n_checks++;
    if ({din_ready, busy, done, pal_clk, pal_cfg} !== 5'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b expected 00000", {din_ready, busy, done, pal_clk, pal_cfg});
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, din_ready, pal_clk} !== 3'b0) begin
      n_fail++;
      $display("FAIL midreset_stays_idle: got %b expected 000", {busy, din_ready, pal_clk});
    end
    din_valid = 0;
    @(negedge clk);
    drive_load(0, -1, -1, 0, done_at, done_cnt, cis, base, eb);
    n_checks++;
    if (done_at !== 58) begin n_fail++; $display("FAIL midreset_reload_done_at: got %0d expected 58", done_at); end
    n_checks++;
    if (pulses - base !== 27) begin n_fail++; $display("FAIL midreset_reload_pulses: got %0d expected 27", pulses - base); end
    n_checks++;
    if (get_stream(0, base, 27) !== 32'h0410_4104) begin
      n_fail++;
      $display("FAIL midreset_reload_stream: got %h expected 04104104", get_stream(0, base, 27));
    end
  endtask
  task automatic test_ignored_start();
    int done_at, done_cnt, cis, base, eb;
    drive_load(0, 5, 30, 1, done_at, done_cnt, cis, base, eb);
    n_checks++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL ign_done_count: got %0d expected 1", done_cnt); end
    n_checks++;
    if (done_at !== 58) begin n_fail++; $display("FAIL ign_done_at: got %0d expected 58", done_at); end
    n_checks++;
    if (pulses - base !== 27) begin n_fail++; $display("FAIL ign_pulses: got %0d expected 27", pulses - base); end
    repeat (4) @(negedge clk);
    n_checks++;
    if ({busy, din_ready, done} !== 3'b0) begin
      n_fail++;
      $display("FAIL ign_idle_after: got %b expected 000", {busy, din_ready, done});
    end
  endtask
  initial begin
    test_reset();
    test_default();
    test_backpressure();
    test_exact_fit();
    test_reset_mid_load();
    test_ignored_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
